// File: rtl/lidar_bitstream_scheduler.sv
// lidar_bitstream_scheduler
//   Round-robin scheduler sharing one LiDAR bitstream reader among NUM_SRC
//   compressed-frame sources. One source is granted at a time; its frame word
//   is latched, offered to the reader until it is not full, then the reader's
//   verdict (data_valid / crc_error / timeout) is reported as a tagged result.
//
//   Optional build macro: BSCHED_CRC_RETRY_EN -- re-issue the latched word on
//   a CRC error, up to MAX_RETRY times, before reporting a failure.
//
// Ports
//   clk, reset            clock, async active-high reset
//   src_valid/src_data    per-source frame request and 512-bit word
//   src_ready             one-hot accept pulse (GRANT cycle)
//   rd_data_in_valid      word offered to the reader (ISSUE)
//   rd_compressed_data    latched frame word
//   rd_buffer_full        reader backpressure
//   rd_data_valid         reader decode OK
//   rd_crc_error          reader CRC failure
//   res_valid/res_src     one-cycle result pulse and source tag
//   res_ok/res_timeout    result cause
//   busy                  any state other than IDLE
//   err_count             saturating count of failed frames
module lidar_bitstream_scheduler #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 512,
  parameter int TIMEOUT   = 256,
  parameter int MAX_RETRY = 2,
  localparam int SRC_W    = $clog2(NUM_SRC)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic                        rd_data_in_valid,
  output logic [DATA_W-1:0]           rd_compressed_data,
  input  logic                        rd_buffer_full,
  input  logic                        rd_data_valid,
  input  logic                        rd_crc_error,
  output logic                        res_valid,
  output logic [SRC_W-1:0]            res_src,
  output logic                        res_ok,
  output logic                        res_timeout,
  output logic                        busy,
  output logic [15:0]                 err_count
);

  localparam int TM_W = $clog2(TIMEOUT);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t            state, nxt;
  logic [SRC_W-1:0]  grant, last_grant, pick, cand;
  logic              req;
  logic [TM_W-1:0]   timer;
  logic              fin_ok, fin_to;

`ifdef BSCHED_CRC_RETRY_EN
  localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RETRY);
  logic [RC_W-1:0] retry_cnt;
  logic            retry_take;
`else
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  // Rotating priority: first requester above last_grant, wrapping around.
  always_comb begin
    pick = last_grant;
    req  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
      if (!req && src_valid[cand]) begin
        pick = cand;
        req  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt    = state;
    fin_ok = 1'b0;
    fin_to = 1'b0;
`ifdef BSCHED_CRC_RETRY_EN
    retry_take = 1'b0;
`endif
    case (state)
      S_IDLE:  if (req) nxt = S_GRANT;
      S_GRANT: nxt = S_ISSUE;
      S_ISSUE: if (!rd_buffer_full) nxt = S_WAIT;
      S_WAIT: begin
        // crc_error outranks data_valid when both arrive together
        if (rd_crc_error) begin
`ifdef BSCHED_CRC_RETRY_EN
          if (retry_cnt < RC_MAX) begin
            nxt        = S_ISSUE;
            retry_take = 1'b1;
          end else begin
            nxt = S_DONE;
          end
`else
          nxt = S_DONE;
`endif
        end else if (rd_data_valid) begin
          nxt    = S_DONE;
          fin_ok = 1'b1;
        end else if (timer == TM_LAST) begin
          nxt    = S_DONE;
          fin_to = 1'b1;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with
  // the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant              <= '0;
      last_grant         <= SRC_W'(NUM_SRC - 1);
      rd_compressed_data <= '0;
      timer              <= '0;
      src_ready          <= '0;
      rd_data_in_valid   <= 1'b0;
      res_valid          <= 1'b0;
      res_src            <= '0;
      res_ok             <= 1'b0;
      res_timeout        <= 1'b0;
      busy               <= 1'b0;
      err_count          <= '0;
    end else begin
      src_ready <= '0;
      if (state == S_IDLE && req) begin
        grant     <= pick;
        src_ready <= NUM_SRC'(1) << pick;
      end
      if (state == S_GRANT)
        rd_compressed_data <= src_data[int'(grant)*DATA_W +: DATA_W];
      if (state == S_ISSUE && !rd_buffer_full) timer <= '0;
      else if (state == S_WAIT)                timer <= timer + 1'b1;
      if (state == S_DONE) last_grant <= grant;

      rd_data_in_valid <= (nxt == S_ISSUE);
      busy             <= (nxt != S_IDLE);
      res_valid        <= (nxt == S_DONE);
      if (state == S_WAIT && nxt == S_DONE) begin
        res_src     <= grant;
        res_ok      <= fin_ok;
        res_timeout <= fin_to;
        if (!fin_ok && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

`ifdef BSCHED_CRC_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                retry_cnt <= '0;
    else if (state == S_GRANT) retry_cnt <= '0;
    else if (retry_take)      retry_cnt <= retry_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_lidar_bitstream_scheduler.sv
// Self-checking bench for lidar_bitstream_scheduler: directed scenarios plus
// randomized frames, checked against a transaction-level reference model.
module tb_lidar_bitstream_scheduler;
  localparam int NS = 4;
  localparam int DW = 512;
  localparam int TO = 256;
  localparam int MR = 2;
`ifdef BSCHED_CRC_RETRY_EN
  localparam int ATTEMPTS = MR + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NS-1:0]     src_valid;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_ready;
  logic              rd_data_in_valid;
  logic [DW-1:0]     rd_compressed_data;
  logic              rd_buffer_full, rd_data_valid, rd_crc_error;
  logic              res_valid;
  logic [1:0]        res_src;
  logic              res_ok, res_timeout, busy;
  logic [15:0]       err_count;

  lidar_bitstream_scheduler #(
    .NUM_SRC(NS), .DATA_W(DW), .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .rd_data_in_valid(rd_data_in_valid), .rd_compressed_data(rd_compressed_data),
    .rd_buffer_full(rd_buffer_full), .rd_data_valid(rd_data_valid),
    .rd_crc_error(rd_crc_error),
    .res_valid(res_valid), .res_src(res_src), .res_ok(res_ok),
    .res_timeout(res_timeout), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state
  logic [NS-1:0] pend;
  logic [DW-1:0] word [NS];
  int            last;
  int            errs;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < DW/32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int rr_next();
    for (int k = 1; k <= NS; k++) begin
      int idx;
      idx = (last + k) % NS;
      if (((pend >> idx) & NS'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic set_src(input int i);
    word[i] = rand_word();
    src_data[i*DW +: DW] = word[i];
    pend = pend | (NS'(1) << i);
    src_valid = pend;
  endtask

  task automatic drop_src(input int i);
    pend = pend & ~(NS'(1) << i);
    src_valid = pend;
    src_data[i*DW +: DW] = rand_word();  // later data must not leak in
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, DW'(src_ready), DW'(0));
    chk({tag, "_inv"},   DW'(rd_data_in_valid), DW'(0));
    chk({tag, "_word"},  rd_compressed_data, DW'(0));
    chk({tag, "_resv"},  DW'(res_valid), DW'(0));
    chk({tag, "_src"},   DW'(res_src), DW'(0));
    chk({tag, "_ok"},    DW'(res_ok), DW'(0));
    chk({tag, "_to"},    DW'(res_timeout), DW'(0));
    chk({tag, "_busy"},  DW'(busy), DW'(0));
    chk({tag, "_err"},   DW'(err_count), DW'(0));
  endtask

  // mode: 0 ok, 1 crc every attempt, 2 silent, 3 crc then ok, 4 crc then silent
  task automatic run_frame(input int mode, input int stall, input int dly,
                           input bit refill, input bit after_done, input bit rnd);
    int exp_src, n, acc, outcome, acc_cyc, st;
    bit crc, silent, done;
    logic [DW-1:0] w;
    if (pend == '0) set_src($urandom_range(NS-1));
    exp_src = rr_next();
    n = 0;
    do begin
      tick();
      n++;
      if (after_done && n == 1) begin
        chk("idle_busy", DW'(busy), DW'(0));
        chk("idle_res", DW'(res_valid), DW'(0));
      end
    end while (src_ready == '0 && n < 8);
    if (after_done) chk("spacing", DW'(n), DW'(2));
    chk("grant", DW'(src_ready), DW'(NS'(1) << exp_src));
    chk("grant_busy", DW'(busy), DW'(1));
    w = word[exp_src];
    tick();  // ISSUE
    drop_src(exp_src);
    if (refill) set_src(exp_src);
    if (rnd)
      for (int i = 0; i < NS; i++)
        if (((pend >> i) & NS'(1)) == '0 && $urandom_range(3) == 0) set_src(i);
    acc = 0; outcome = 0; done = 0; st = stall; acc_cyc = cyc;
    while (!done && acc < 8) begin
      for (int s = 0; s <= st; s++) begin
        chk("in_valid", DW'(rd_data_in_valid), DW'(1));
        chk("word", rd_compressed_data, w);
        chk("issue_ready", DW'(src_ready), DW'(0));
        rd_buffer_full = (s < st);
        rd_data_valid  = 1'($urandom_range(1));  // ignored outside WAIT
        rd_crc_error   = 1'($urandom_range(1));
        if (s < st) tick();
      end
      acc++;
      acc_cyc = cyc;
      tick();  // first WAIT cycle
      rd_data_valid  = 1'b0;
      rd_crc_error   = 1'b0;
      rd_buffer_full = 1'($urandom_range(1));
      chk("wait_inv", DW'(rd_data_in_valid), DW'(0));
      crc    = (mode == 1) || ((mode == 3 || mode == 4) && acc == 1);
      silent = !crc && (mode == 2 || mode == 4);
      if (silent) begin
        n = 0;
        while (!res_valid && n < TO + 8) begin
          tick();
          n++;
        end
        chk("timeout_lat", DW'(cyc - acc_cyc), DW'(TO + 1));
        outcome = 2;
        done = 1;
      end else begin
        for (int d = 0; d < dly; d++) begin
          chk("wait_quiet", DW'(res_valid), DW'(0));
          tick();
        end
        rd_crc_error  = crc;
        rd_data_valid = crc ? 1'($urandom_range(1)) : 1'b1;
        tick();
        rd_crc_error  = 1'b0;
        rd_data_valid = 1'b0;
        if (!crc) begin
          outcome = 0;
          done = 1;
        end else if (acc >= ATTEMPTS) begin
          outcome = 1;
          done = 1;
        end else begin
          st = $urandom_range(2);
        end
      end
    end
    rd_buffer_full = 1'b0;
    if (outcome != 0) errs++;
    last = exp_src;
    chk("res_valid", DW'(res_valid), DW'(1));
    chk("res_src", DW'(res_src), DW'(exp_src));
    chk("res_ok", DW'(res_ok), DW'(outcome == 0));
    chk("res_timeout", DW'(res_timeout), DW'(outcome == 2));
    chk("err_count", DW'(err_count), DW'(errs));
    chk("done_busy", DW'(busy), DW'(1));
  endtask

  initial begin
    int gsrc, n;
    reset = 1'b1;
    src_valid = '0; src_data = '0; pend = '0;
    rd_buffer_full = 1'b0; rd_data_valid = 1'b0; rd_crc_error = 1'b0;
    last = NS - 1; errs = 0;
    for (int i = 0; i < NS; i++) word[i] = '0;
    tick(); tick();
    chk_reset_outs("rst");
    reset = 1'b0;
    tick();
    chk_reset_outs("idle");

    // sources 0 and 2 together, quick reader response
    set_src(0); set_src(2);
    run_frame(0, 0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 1, 0);
    // source 1 alone, 10 cycles of buffer_full
    set_src(1);
    run_frame(0, 10, 1, 0, 1, 0);
    // reader silent
    set_src(3);
    run_frame(2, 0, 0, 0, 1, 0);
    // crc on every attempt
    set_src(0);
    run_frame(1, 1, 0, 0, 1, 0);
    // crc then ok; crc then silent (timer restarts on re-issue)
    set_src(2);
    run_frame(3, 0, 2, 0, 1, 0);
    set_src(1);
    run_frame(4, 0, 0, 0, 1, 0);

    // reset in the middle of WAIT, all sources requesting
    for (int i = 0; i < NS; i++) set_src(i);
    n = 0;
    do begin tick(); n++; end while (src_ready == '0 && n < 8);
    gsrc = rr_next();
    chk("abort_grant", DW'(src_ready), DW'(NS'(1) << gsrc));
    tick();
    set_src(gsrc);  // served source immediately offers a new frame
    rd_buffer_full = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk_reset_outs("abort_async");
    tick();
    chk_reset_outs("abort");
    reset = 1'b0;
    last = NS - 1;
    errs = 0;
    // all four held valid: 0,1,2,3,0,1,2,3
    for (int f = 0; f < 8; f++)
      run_frame(0, $urandom_range(2), $urandom_range(2), 1, f != 0, 0);
    for (int i = 0; i < NS; i++) drop_src(i);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      int r, mode;
      r = $urandom_range(19);
      mode = (r < 10) ? 0 : (r < 14) ? 1 : (r < 17) ? 3 : (r < 18) ? 4 : (r < 19) ? 2 : 0;
      run_frame(mode, $urandom_range(3), $urandom_range(3),
                1'($urandom_range(1)), 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=stalled exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lidar_bitstream_scheduler.md
# lidar_bitstream_scheduler

Round-robin scheduler that shares one LiDAR bitstream reader among several compressed-frame sources. Grants one source at a time, issues its 512-bit frame word to the reader under `buffer_full` backpressure, and waits for `data_valid`, `crc_error` or a timeout. Reports a tagged per-frame result and keeps a saturating error count. Sits between the sensor-side packet front-ends and the bitstream reader in the LiDAR decoder.

## Interface
- `NUM_SRC`, default 4: number of requesters, 2..8.
- `DATA_W`, default 512: frame word width.
- `TIMEOUT`, default 256: WAIT-state cycles allowed before the frame is declared timed out, ≥2.
- `MAX_RETRY`, default 2: re-issues allowed after a CRC error (retry build only).
- `SRC_W`, derived as $clog2(NUM_SRC); not overridable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `src_valid`  in  NUM_SRC  per-source frame-available; once raised, held until that source's `src_ready`.
- `src_data`  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- `src_ready`  out  NUM_SRC  one-hot, one-cycle accept pulse.
- `rd_data_in_valid`  out  1  to reader `data_in_valid`.
- `rd_compressed_data`  out  DATA_W  to reader `compressed_data`.
- `rd_buffer_full`  in  1  from reader `buffer_full`.
- `rd_data_valid`  in  1  from reader `data_valid`.
- `rd_crc_error`  in  1  from reader `crc_error`.
- `res_valid`  out  1  one-cycle result pulse.
- `res_src`  out  SRC_W  source index of the result.
- `res_ok`  out  1  1 means decoded OK; 0 means CRC failure or timeout.
- `res_timeout`  out  1  1 when the failure cause is timeout.
- `busy`  out  1  high in every state except IDLE.
- `err_count`  out  16  failed frames, saturates at 0xFFFF.

## Operation
- **IDLE**
  - If any `src_valid` is high, pick the first set bit searching upward from `last_grant+1` with wrap.
  - Register the pick into `grant` and go to GRANT.
- **GRANT**
  - `src_ready[grant]=1` for exactly one cycle.
  - Latch `src_data[grant]` into the frame register; clear `retry_cnt`; go to ISSUE.
- **ISSUE**
  - `rd_data_in_valid=1` and `rd_compressed_data`=frame register.
  - If `rd_buffer_full=0` in this cycle, the word is accepted: clear `timer`, go to WAIT.
  - If `rd_buffer_full=1`, stay in ISSUE with data held. There is no timeout in ISSUE.
- **WAIT**
  - `rd_data_in_valid=0`; `timer` increments each cycle.
  - Check in priority order (first match wins):
    - `rd_crc_error=1` → CRC handling; it wins over `rd_data_valid` if both are high.
    - `rd_data_valid=1` → DONE with ok.
    - `timer==TIMEOUT-1` → DONE with timeout.
- **CRC handling**
  - With retry: if `retry_cnt<MAX_RETRY`, increment `retry_cnt` and return to ISSUE with the same latched word. Otherwise go to DONE with fail.
  - Without retry: go to DONE with fail.
- **DONE**
  - `res_valid=1`; `res_src=grant`; `res_ok` and `res_timeout` are set per cause.
  - If failed, `err_count` increments (saturating).
  - `last_grant<=grant`; go to IDLE.
- `rd_data_valid` or `rd_crc_error` seen outside WAIT is ignored.
- `src_data` is sampled only in GRANT; later changes have no effect.

## Timing
- Reset values:
  - State IDLE, `last_grant=NUM_SRC-1` (so source 0 has first priority).
  - `src_ready=0`, `rd_data_in_valid=0`, `rd_compressed_data=0`.
  - `res_valid=0`, `res_src=0`, `res_ok=0`, `res_timeout=0`, `busy=0`, `err_count=0`.
- All outputs are registered.
- Reset asserted mid-frame aborts immediately: no `res_valid` is produced and the frame is dropped.
- Best-case latency, with `src_valid` seen in IDLE at cycle t:
  - `src_ready` at t+1.
  - `rd_data_in_valid` at t+2.
  - WAIT from t+3.
  - If the reader responds at cycle w, `res_valid` is at w+1.
  - Earliest result is t+4.
- Minimum frame-to-frame spacing is 5 cycles (IDLE, GRANT, ISSUE, WAIT, DONE).
- Timeout: the result pulse comes exactly TIMEOUT+1 cycles after the ISSUE-accept cycle.
- Each retry returns to ISSUE and restarts `timer` at 0.

## Configuration
- Macro `BSCHED_CRC_RETRY_EN`.
- Defined: CRC-error re-issue up to MAX_RETRY times, with `retry_cnt` of width $clog2(MAX_RETRY+1).
- Undefined: no retry logic is built, MAX_RETRY is ignored, and the first `rd_crc_error` in WAIT yields a fail result.

## Test plan
1. Sources 0 and 2 valid together from reset; reader returns `data_valid` 1 cycle into WAIT → results for src 0 then src 2, both `res_ok=1`, `err_count=0`.
2. Only source 1 valid; `rd_buffer_full=1` for 10 cycles during ISSUE → `rd_data_in_valid` held 11 cycles with a stable word; word accepted on the first not-full cycle; then a normal ok result.
3. Reader silent after accept, TIMEOUT=256 → `res_valid` 257 cycles after accept; `res_ok=0`, `res_timeout=1`, `err_count=1`.
4. Retry build, MAX_RETRY=2; `crc_error` on every attempt → 3 ISSUE accepts, then `res_ok=0`, `res_timeout=0`. Non-retry build → 1 accept, then fail.
5. All 4 sources held valid for 8 frames → grant order 0,1,2,3,0,1,2,3 and exactly one `src_ready` pulse per frame.
6. Reset pulsed during WAIT → all outputs return to reset values, no `res_valid`; the next grant goes to source 0.
